// File: rtl/params_pkg.sv
// Shared widths and writeback types for the writeback scheduler and its source FIFOs.
package params_pkg;

  localparam int ROB_ENTRY_WIDTH = 6;
  localparam int REGISTER_WIDTH  = 5;
  localparam int DATA_WIDTH      = 32;
  localparam int WB_NUM_SRC      = 3;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_EX   = 2'd2,
    WB_SRC_ALU  = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic                       wr_en;
    logic [ROB_ENTRY_WIDTH-1:0] rob_idx;
    logic [REGISTER_WIDTH-1:0]  wr_reg;
    logic [DATA_WIDTH-1:0]      data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_src_fifo.sv
// Small per-producer result FIFO; head is always the oldest entry, pointers wrap naturally.
module wb_src_fifo
  import params_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WB_ENTRY_W-1:0] data_i,
  output logic [WB_ENTRY_W-1:0] head_o,
  output logic [CW-1:0]         count_o
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WB_ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [CW-1:0]         count_q;

  // Storage array: written on push only, contents need no reset
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_ONE;
      else        wptr_q <= wptr_q;
      if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
      else        rptr_q <= rptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: three buffered producers (MEM, EX, ALU) share one registered
// writeback port, MEM first, with starved EX/ALU heads forced through after a bounded wait.
module wb_scheduler
  import params_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int REGISTER_WIDTH  = params_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH      = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       mem_valid_i,
  input  logic                       ex_valid_i,
  input  logic                       alu_valid_i,
  output logic                       mem_ready_o,
  output logic                       ex_ready_o,
  output logic                       alu_ready_o,
  input  logic                       mem_wr_en_i,
  input  logic                       ex_wr_en_i,
  input  logic                       alu_wr_en_i,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_idx_i,
  input  logic [ROB_ENTRY_WIDTH-1:0] ex_rob_idx_i,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_idx_i,
  input  logic [REGISTER_WIDTH-1:0]  mem_wr_reg_i,
  input  logic [REGISTER_WIDTH-1:0]  ex_wr_reg_i,
  input  logic [REGISTER_WIDTH-1:0]  alu_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]      mem_data_i,
  input  logic [DATA_WIDTH-1:0]      ex_data_i,
  input  logic [DATA_WIDTH-1:0]      alu_data_i,
  output logic                       wb_valid_o,
  output logic                       reg_wr_en_o,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_idx_o,
  output logic [REGISTER_WIDTH-1:0]  wr_reg_o,
  output logic [DATA_WIDTH-1:0]      data_to_reg_o,
  output logic [1:0]                 wb_src_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  // Source index 0 = MEM, 1 = EX, 2 = ALU throughout
  logic [WB_NUM_SRC-1:0] valid_in;
  logic [WB_NUM_SRC-1:0] ready;
  logic [WB_NUM_SRC-1:0] push;
  logic [WB_NUM_SRC-1:0] pop;
  logic [WB_NUM_SRC-1:0] nonempty;
  logic [WB_NUM_SRC-1:0] starved;
  wb_entry_t             entry_in [WB_NUM_SRC];
  wb_entry_t             head     [WB_NUM_SRC];
  logic [CW-1:0]         count    [WB_NUM_SRC];
  logic [WW-1:0]         wait_q   [WB_NUM_SRC];
  wb_src_t               grant;
  wb_entry_t             sel;

  logic                       wb_valid_q;
  logic                       reg_wr_en_q;
  logic [ROB_ENTRY_WIDTH-1:0] rob_idx_q;
  logic [REGISTER_WIDTH-1:0]  wr_reg_q;
  logic [DATA_WIDTH-1:0]      data_q;
  wb_src_t                    src_q;

  assign valid_in    = {alu_valid_i, ex_valid_i, mem_valid_i};
  assign entry_in[0] = {mem_wr_en_i, mem_rob_idx_i, mem_wr_reg_i, mem_data_i};
  assign entry_in[1] = {ex_wr_en_i, ex_rob_idx_i, ex_wr_reg_i, ex_data_i};
  assign entry_in[2] = {alu_wr_en_i, alu_rob_idx_i, alu_wr_reg_i, alu_data_i};

  for (genvar i = 0; i < WB_NUM_SRC; i++) begin : g_src
    // Ready looks only at the pre-pop count, so a full FIFO never takes a push while popping
    assign ready[i]    = (count[i] < DEPTH_C) & ~flush_i & rst_ni;
    assign push[i]     = valid_in[i] & ready[i];
    assign nonempty[i] = (count[i] != '0);
    assign starved[i]  = nonempty[i] & (wait_q[i] == WAIT_MAX);

    wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (entry_in[i]),
      .head_o  (head[i]),
      .count_o (count[i])
    );
  end

  assign mem_ready_o = ready[0];
  assign ex_ready_o  = ready[1];
  assign alu_ready_o = ready[2];

  // Grant selection: starved heads win in ALU > EX > MEM order, otherwise MEM > EX > ALU
  always_comb begin
    grant = WB_SRC_NONE;
    if (!rst_ni || flush_i)   grant = WB_SRC_NONE;
    else if (starved[2])      grant = WB_SRC_ALU;
    else if (starved[1])      grant = WB_SRC_EX;
    else if (starved[0])      grant = WB_SRC_MEM;
    else if (nonempty[0])     grant = WB_SRC_MEM;
    else if (nonempty[1])     grant = WB_SRC_EX;
    else if (nonempty[2])     grant = WB_SRC_ALU;
    else                      grant = WB_SRC_NONE;
  end

  assign pop[0] = (grant == WB_SRC_MEM);
  assign pop[1] = (grant == WB_SRC_EX);
  assign pop[2] = (grant == WB_SRC_ALU);

  // Payload mux for the granted head; zero when nothing is granted
  always_comb begin
    sel = '0;
    case (grant)
      WB_SRC_MEM: sel = head[0];
      WB_SRC_EX:  sel = head[1];
      WB_SRC_ALU: sel = head[2];
      default:    sel = '0;
    endcase
  end

  // Registered writeback port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      reg_wr_en_q <= 1'b0;
      rob_idx_q   <= '0;
      wr_reg_q    <= '0;
      data_q      <= '0;
      src_q       <= WB_SRC_NONE;
    end else begin
      wb_valid_q  <= (grant != WB_SRC_NONE);
      reg_wr_en_q <= (grant != WB_SRC_NONE) & sel.wr_en;
      rob_idx_q   <= sel.rob_idx;
      wr_reg_q    <= sel.wr_reg;
      data_q      <= sel.data;
      src_q       <= grant;
    end
  end

  // Wait counters saturate at the limit; cleared whenever the source is empty or served
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      if (!rst_ni || flush_i)          wait_q[i] <= '0;
      else if (!nonempty[i] || pop[i]) wait_q[i] <= '0;
      else if (wait_q[i] != WAIT_MAX)  wait_q[i] <= wait_q[i] + WAIT_ONE;
      else                             wait_q[i] <= wait_q[i];
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign rob_idx_o     = rob_idx_q;
  assign wr_reg_o      = wr_reg_q;
  assign data_to_reg_o = data_q;
  assign wb_src_o      = src_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: a queue-based reference model predicts every
// writeback cycle, and a monitor compares the registered port after each clock edge.
module tb_wb_scheduler;
  import params_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [5:0]  rob;
    logic [4:0]  rg;
    logic [31:0] d;
    logic [1:0]  src;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni = 1'b0, flush_i = 1'b0;
  logic        mem_valid_i = 1'b0, ex_valid_i = 1'b0, alu_valid_i = 1'b0;
  logic        mem_ready_o, ex_ready_o, alu_ready_o;
  logic        mem_wr_en_i = 1'b0, ex_wr_en_i = 1'b0, alu_wr_en_i = 1'b0;
  logic [5:0]  mem_rob_idx_i = '0, ex_rob_idx_i = '0, alu_rob_idx_i = '0;
  logic [4:0]  mem_wr_reg_i = '0, ex_wr_reg_i = '0, alu_wr_reg_i = '0;
  logic [31:0] mem_data_i = '0, ex_data_i = '0, alu_data_i = '0;
  logic        wb_valid_o, reg_wr_en_o;
  logic [5:0]  rob_idx_o;
  logic [4:0]  wr_reg_o;
  logic [31:0] data_to_reg_o;
  logic [1:0]  wb_src_o;

  wb_scheduler #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .ex_valid_i(ex_valid_i), .alu_valid_i(alu_valid_i),
    .mem_ready_o(mem_ready_o), .ex_ready_o(ex_ready_o), .alu_ready_o(alu_ready_o),
    .mem_wr_en_i(mem_wr_en_i), .ex_wr_en_i(ex_wr_en_i), .alu_wr_en_i(alu_wr_en_i),
    .mem_rob_idx_i(mem_rob_idx_i), .ex_rob_idx_i(ex_rob_idx_i), .alu_rob_idx_i(alu_rob_idx_i),
    .mem_wr_reg_i(mem_wr_reg_i), .ex_wr_reg_i(ex_wr_reg_i), .alu_wr_reg_i(alu_wr_reg_i),
    .mem_data_i(mem_data_i), .ex_data_i(ex_data_i), .alu_data_i(alu_data_i),
    .wb_valid_o(wb_valid_o), .reg_wr_en_o(reg_wr_en_o), .rob_idx_o(rob_idx_o),
    .wr_reg_o(wr_reg_o), .data_to_reg_o(data_to_reg_o), .wb_src_o(wb_src_o)
  );

  // Reference model state: per-source queues of buffered results and wait ages
  wb_entry_t mq [3][$];
  int        wt [3];
  out_t      exp_q [$];
  logic [2:0] acc;

  // Producer side: a pending result is held until accepted
  logic      pv [3];
  wb_entry_t pe [3];
  int        prob [3];

  int checks = 0;
  int failures = 0;

  function automatic wb_entry_t mk(input logic we, input int rob, input int rg, input int d);
    wb_entry_t e;
    e.wr_en   = we;
    e.rob_idx = rob[5:0];
    e.wr_reg  = rg[4:0];
    e.data    = d;
    return e;
  endfunction

  // One clock edge of the reference model, using the inputs presented for that edge
  task automatic model_step(input logic rst, input logic fl);
    out_t o;
    int g;
    wb_entry_t e;
    o = '0;
    g = -1;
    acc = 3'b000;
    if (!rst || fl) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        wt[i] = 0;
      end
    end else begin
      for (int i = 2; i >= 0; i--)
        if (g < 0 && mq[i].size() > 0 && wt[i] == LIMIT) g = i;
      for (int i = 0; i < 3; i++)
        if (g < 0 && mq[i].size() > 0) g = i;
      for (int i = 0; i < 3; i++) begin
        acc[i] = pv[i] && (mq[i].size() < DEPTH);
        if (mq[i].size() == 0 || i == g) wt[i] = 0;
        else if (wt[i] < LIMIT) wt[i] = wt[i] + 1;
      end
      if (g >= 0) begin
        e = mq[g].pop_front();
        o.v   = 1'b1;
        o.we  = e.wr_en;
        o.rob = e.rob_idx;
        o.rg  = e.wr_reg;
        o.d   = e.data;
        o.src = 2'(g + 1);
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) mq[i].push_back(pe[i]);
    end
    exp_q.push_back(o);
  endtask

  // Drive one cycle: refresh producers, present inputs, check ready, advance model
  task automatic cycle(input logic rst, input logic fl);
    logic [2:0] rdy_got;
    logic [2:0] rdy_exp;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!pv[i] && $urandom_range(99) < prob[i]) begin
        pv[i] = 1'b1;
        pe[i] = mk(1'($urandom), int'($urandom_range(63)), int'($urandom_range(31)), int'($urandom));
      end
    end
    rst_ni = rst;
    flush_i = fl;
    mem_valid_i = pv[0]; mem_wr_en_i = pe[0].wr_en; mem_rob_idx_i = pe[0].rob_idx;
    mem_wr_reg_i = pe[0].wr_reg; mem_data_i = pe[0].data;
    ex_valid_i = pv[1]; ex_wr_en_i = pe[1].wr_en; ex_rob_idx_i = pe[1].rob_idx;
    ex_wr_reg_i = pe[1].wr_reg; ex_data_i = pe[1].data;
    alu_valid_i = pv[2]; alu_wr_en_i = pe[2].wr_en; alu_rob_idx_i = pe[2].rob_idx;
    alu_wr_reg_i = pe[2].wr_reg; alu_data_i = pe[2].data;
    #1;
    rdy_got = {alu_ready_o, ex_ready_o, mem_ready_o};
    for (int i = 0; i < 3; i++) rdy_exp[i] = rst && !fl && (mq[i].size() < DEPTH);
    checks++;
    if (rdy_got !== rdy_exp) begin
      failures++;
      $display("FAIL ready t=%0t got=%b expected=%b", $time, rdy_got, rdy_exp);
    end
    model_step(rst, fl);
    for (int i = 0; i < 3; i++)
      if (acc[i] || !rst || fl) pv[i] = 1'b0;
  endtask

  task automatic set_probs(input int m, input int x, input int a);
    prob[0] = m; prob[1] = x; prob[2] = a;
  endtask

  task automatic idle(input int n);
    set_probs(0, 0, 0);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0);
  endtask

  // Monitor: after each edge compare the writeback port against the predicted cycle
  always @(posedge clk) begin
    out_t e;
    out_t got;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {wb_valid_o, reg_wr_en_o, rob_idx_o, wr_reg_o, data_to_reg_o, wb_src_o};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL wb_out t=%0t got v=%0b we=%0b src=%0d rob=%0d reg=%0d data=%h expected v=%0b we=%0b src=%0d rob=%0d reg=%0d data=%h",
                 $time, got.v, got.we, got.src, got.rob, got.rg, got.d,
                 e.v, e.we, e.src, e.rob, e.rg, e.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pe[i] = '0;
      wt[i] = 0;
    end
    set_probs(0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
    idle(2);

    // Single ALU result into an idle block
    pv[2] = 1'b1; pe[2] = mk(1'b1, 5, 3, 32'hA5);
    idle(3);

    // All three producers in the same cycle
    pv[0] = 1'b1; pe[0] = mk(1'b1, 10, 1, 32'h1111);
    pv[1] = 1'b1; pe[1] = mk(1'b0, 11, 2, 32'h2222);
    pv[2] = 1'b1; pe[2] = mk(1'b1, 12, 4, 32'h3333);
    idle(5);

    // Continuous loads with one EX result waiting
    pv[1] = 1'b1; pe[1] = mk(1'b1, 20, 7, 32'hBEEF);
    set_probs(100, 0, 0);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0);
    idle(4);

    // ALU FIFO fills and back-pressures while loads stream
    set_probs(100, 0, 100);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0);
    idle(8);

    // Flush with buffered EX/MEM results and an ALU push in the flush cycle
    pv[0] = 1'b1; pe[0] = mk(1'b1, 30, 8, 32'h30);
    pv[1] = 1'b1; pe[1] = mk(1'b1, 31, 9, 32'h31);
    idle(1);
    pv[1] = 1'b1; pe[1] = mk(1'b1, 32, 10, 32'h32);
    idle(1);
    pv[2] = 1'b1; pe[2] = mk(1'b1, 33, 11, 32'h33);
    cycle(1'b1, 1'b1);
    idle(4);

    // Reset mid-stream with full FIFOs
    set_probs(100, 100, 100);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    idle(4);

    // Randomised traffic with occasional flush and reset
    for (int blk = 0; blk < 30; blk++) begin
      set_probs(int'($urandom_range(100)), int'($urandom_range(100)), int'($urandom_range(100)));
      for (int k = 0; k < 50; k++) begin
        cycle(($urandom_range(99) != 0), ($urandom_range(49) == 0));
      end
    end
    idle(6);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
Name: wb_scheduler

Overview:
- Buffered writeback scheduler that sits between the MEM, EX and ALU result producers and the single register-file/ROB writeback port.
- Each producer pushes results through a valid/ready handshake into a private small FIFO.
- One result per cycle is granted to a registered writeback port.
- Base priority is MEM > EX > ALU, with an anti-starvation override so that EX and ALU results cannot be blocked indefinitely by a stream of loads.

Parameters:
ROB_ENTRY_WIDTH, params_pkg::ROB_ENTRY_WIDTH, ROB index width
REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, architectural register index width
DATA_WIDTH, params_pkg::DATA_WIDTH, result data width
FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)
STARVE_LIMIT, 4, cycles a non-empty source head may wait before forced grant (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  pipeline flush; discard all buffered results
mem_valid_i / ex_valid_i / alu_valid_i  in  1 each  producer has a result
mem_ready_o / ex_ready_o / alu_ready_o  out  1 each  FIFO can accept
mem_wr_en_i / ex_wr_en_i / alu_wr_en_i  in  1 each  result writes a register
mem_rob_idx_i / ex_rob_idx_i / alu_rob_idx_i  in  ROB_ENTRY_WIDTH each  ROB entry
mem_wr_reg_i / ex_wr_reg_i / alu_wr_reg_i  in  REGISTER_WIDTH each  destination register
mem_data_i / ex_data_i / alu_data_i  in  DATA_WIDTH each  result data
wb_valid_o  out  1  writeback occurs this cycle (marks ROB entry completed)
reg_wr_en_o  out  1  register-file write enable (wb_valid_o & granted wr_en)
rob_idx_o  out  ROB_ENTRY_WIDTH  completed ROB entry
wr_reg_o  out  REGISTER_WIDTH  destination register
data_to_reg_o  out  DATA_WIDTH  write data
wb_src_o  out  2  granted source, wb_src_t (NONE=0, MEM=1, EX=2, ALU=3)

Behaviour:
- Reset (rst_ni=0 at posedge):
  - All FIFOs are emptied and all wait counters are cleared.
  - All outputs are 0 on the following cycle; ready outputs are 0 while rst_ni=0.
  - Reset asserted mid-operation drops buffered results silently.
- Push:
  - x_ready_o = (count_x < FIFO_DEPTH) & ~flush_i & rst_ni. It is combinational from state only, with no dependence on the same-cycle pop.
  - An entry is accepted when x_valid_i & x_ready_o at posedge.
  - valid asserted while ready=0: the result is not stored; the producer must hold it.
- Grant (combinational from FIFO heads, registered into the output):
  - A source x is starved when its head is non-empty and wait_x == STARVE_LIMIT.
  - If any source is starved, the grant order is ALU > EX > MEM among starved sources. Otherwise the order is MEM > EX > ALU among non-empty sources.
  - The granted head is popped at the same posedge its payload is registered into the outputs.
  - Latency: a result pushed at edge N can appear on wb_* after edge N+1 at the earliest (1-cycle FIFO-to-output).
  - No grant: wb_valid_o=0, reg_wr_en_o=0, wb_src_o=NONE, and data/index outputs are 0.
- Wait counters:
  - Each cycle, for each source: if empty or granted, wait=0; else wait=min(wait+1, STARVE_LIMIT).
  - Counters are sized $clog2(STARVE_LIMIT+1) bits.
- Simultaneous push and pop on the same FIFO:
  - Both take effect; count is unchanged; pointers wrap modulo FIFO_DEPTH.
  - A push to a full FIFO in the same cycle as its pop is not accepted, because ready is based on the pre-pop count.
- Flush (flush_i=1 at posedge):
  - All FIFOs are emptied, counters cleared, and no grant is made (wb_valid_o=0 next cycle).
  - Pushes in the flush cycle are ignored.
- Ordering: within one source, results retire in FIFO order. No ordering is guaranteed across sources.

Decomposition:
- params_pkg gains:
  - wb_src_t enum (2-bit).
  - wb_entry_t packed struct {wr_en, rob_idx, wr_reg, data}.
  - WB_NUM_SRC=3.
- Sub-module wb_src_fifo: parameterised FIFO of wb_entry_t with push/pop/flush, count and head outputs. It is instantiated three times.
- The arbiter and wait counters live in wb_scheduler.

Test Plan:
- Single ALU push {rob=5, reg=3, data=0xA5, wr_en=1} into idle block -> next cycle wb_valid_o=1, reg_wr_en_o=1, wb_src_o=ALU, rob_idx_o=5, data_to_reg_o=0xA5; the cycle after, wb_valid_o=0.
- MEM, EX and ALU all push in the same cycle -> grants over three consecutive cycles in order MEM, EX, ALU.
- Continuous MEM stream every cycle with one EX result pending, STARVE_LIMIT=4 -> EX is granted on the 5th cycle after its push edge (wait reaches 4); then MEM resumes.
- Fill ALU FIFO with 2 entries while MEM is busy -> alu_ready_o=0; a third alu_valid_i is held until a pop; once accepted, the third entry retires after the first two in order.
- Load 2 EX and 1 MEM entries, then assert flush_i for one cycle with alu_valid_i=1 -> wb_valid_o=0 for the following cycles; the ALU push is dropped; all ready outputs return to 1 after the flush.
- Assert rst_ni=0 mid-stream with full FIFOs -> next cycle all outputs are 0 and ready outputs are low; after release, the block is empty and nothing is written back.
